md_seq: RTL and testbench

Iterative multiply/divide sequencer for the multicycle MIPS core. It accepts one mult/multu/div/divu/mthi/mtlo command from the main control FSM, performs 32-bit operations as a 32-step shift-add or restoring-divide loop, and writes the HI/LO result registers. It reports completion with a one-cycle `done` pulse, which the control FSM waits on before advancing.

---
 rtl/md_seq.sv | 162 ++++++++++++++++
 tb/tb_md_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/md_seq.sv
// Iterative multiply/divide sequencer: 32-step shift-add multiply, 32-step
// restoring divide, sign fixup, and HI/LO result registers.
module md_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic               neg_q;
  logic               rneg_q;
  logic               div_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sgn_op;
  logic               dz;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul_d;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_dif;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_div_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  always_comb begin
    sgn_op  = (op == OP_MULT) || (op == OP_DIV);
    dz      = (b == '0);
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    acc_mul_d = mplr_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    // 33-bit trial subtract: bit WIDTH set means the shifted remainder was below the divisor
    div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_dif = div_sh - {1'b0, mcand_q};
    div_ge  = ~div_dif[WIDTH];
    acc_div_d = div_ge ? {div_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                       : {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod_fix = neg_q  ? -acc_q : acc_q;
    quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mcand_q <= mag(a, sgn_op);
                mplr_q  <= mag(b, sgn_op);
                neg_q   <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_q  <= 1'b0;
                acc_q   <= '0;
                cnt_q   <= '0;
                div_q   <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                // With a zero divisor every trial succeeds, so the raw dividend
                // shifts through into the remainder and the quotient fills with ones.
                mcand_q <= mag(b, sgn_op);
                acc_q   <= {{WIDTH{1'b0}}, (dz ? a : mag(a, sgn_op))};
                neg_q   <= sgn_op & ~dz & (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_q  <= sgn_op & ~dz & a[WIDTH-1];
                cnt_q   <= '0;
                div_q   <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= S_DIV;
              end
              OP_MTHI: begin
                hi_q   <= a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_q  <= acc_mul_d;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_DIV: begin
          acc_q <= acc_div_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (div_q) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_seq.sv
// Bench for md_seq: vector table run back-to-back through a result scoreboard,
// plus hand sequences for no-op/ignored starts and asynchronous reset mid-divide.
module tb_md_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  md_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb_q[$];
  vec_t        vecs[15];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
    res_t r;
    r.hi = eh;
    r.lo = el;
    sb_q.push_back(r);
  endtask

  task automatic pop_cmp(input string name);
    res_t r;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty actual=%h_%h", name, hi, lo);
    end else begin
      checks--;
      r = sb_q.pop_front();
      chk({name, "_hi"}, hi, r.hi);
      chk({name, "_lo"}, lo, r.lo);
    end
  endtask

  // Called at #1 after an edge; the command is sampled at the next edge (E0).
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int bcnt;
    string nm;
    nm = $sformatf("vec%0d", idx);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    push_exp(v.hi, v.lo);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (lat == 10) begin
        chk({nm, "_hold_hi"}, hi, prev_hi);
        chk({nm, "_hold_lo"}, lo, prev_lo);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_busy_cycles"}, bcnt, v.lat);
    chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    pop_cmp(nm);
    prev_hi = v.hi;
    prev_lo = v.lo;
    if (v.lat == 0) begin
      @(posedge clk); #1;
      chk({nm, "_done_single"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    int n;
    vec_t v;

    vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33};
    vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5]  = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd5, 32'hCAFE0000, 32'h00000000, 32'hCAFE0000, 32'hFFFFFFFF, 0};
    vecs[7]  = '{3'd6, 32'h12345678, 32'h00000000, 32'hCAFE0000, 32'h12345678, 0};
    vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[9]  = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33};
    vecs[10] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[11] = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    vecs[12] = '{3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 33};
    vecs[13] = '{3'd1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 33};
    vecs[14] = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    #19 rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // No-op opcodes must not produce done or touch HI/LO.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; op = (k == 0) ? 3'd0 : 3'd7; a = 32'hDEADBEEF; b = 32'd1;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      n = 0;
      repeat (3) begin
        if (done || busy) n++;
        @(posedge clk); #1;
      end
      chk($sformatf("noop%0d_activity", k), n, 0);
    end
    chk("noop_hi", hi, prev_hi);
    chk("noop_lo", lo, prev_lo);

    // Start presented at E5 while multiplying is dropped, not queued.
    start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
    push_exp(32'd0, 32'd6);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1; op = 3'd4; a = 32'd99; b = 32'd3;
      end else if (lat == 5) begin
        start = 1'b0; op = 3'd0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("ignored_latency", lat, 33);
    pop_cmp("ignored");
    prev_hi = 32'd0; prev_lo = 32'd6;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    chk("no_queued_start", n, 0);

    // Asynchronous reset partway through a divide.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    prev_hi = '0; prev_lo = '0;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    v = '{3'd1, 32'd6, 32'd7, 32'd0, 32'h0000002A, 33};
    run_vec(v, 99);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
